// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the convolution weight fetchers.
//   - ROM geometry (address / data width) of the kernel ROMs.
//   - conv2 kernel shape and the resulting per-kernel weight count.
//   - Base address of conv2 kernel 0 inside a kernel-group ROM.
//   - State encoding used by the kernel fetch controllers.
//   - num_pairs(): number of weight pairs needed to cover a kernel.
// ---------------------------------------------------------------------------
package conv_pkg;

  // Kernel ROM geometry (256 x 16-bit, dual-port, registered read).
  localparam int ROM_ADDR_W = 8;
  localparam int ROM_DATA_W = 16;

  // conv2 kernel shape: 5 x 5 spatial taps over 6 input channels.
  localparam int CONV2_KH  = 5;
  localparam int CONV2_KW  = 5;
  localparam int CONV2_CIN = 6;
  localparam int CONV2_NUM_WEIGHTS = CONV2_KH * CONV2_KW * CONV2_CIN;

  // Each kernel-group ROM stores its kernel starting at word 0.
  localparam int CONV2_BASE_ADDR = 0;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  // Weights are streamed two at a time; an odd count leaves a half pair.
  function automatic int num_pairs(input int n_weights);
    return (n_weights + 1) / 2;
  endfunction

endpackage : conv_pkg

// File: rtl/conv_pair_fifo2.sv
// ---------------------------------------------------------------------------
// conv_pair_fifo2
//   Two-entry synchronous FIFO carrying one weight pair per entry:
//   {data_a, data_b, b_valid, last}. Push and pop in the same cycle are
//   allowed. The head fields read as zero while the FIFO is empty so the
//   downstream interface shows clean zeros when nothing is valid.
//
//   Ports
//     clk_i            clock
//     rst_ni           asynchronous active-low reset
//     flush_i          synchronous clear of all entries (wins over push/pop)
//     push_i           write one entry (caller guarantees room)
//     push_data_a_i    lane A weight
//     push_data_b_i    lane B weight
//     push_b_valid_i   lane B holds a real weight
//     push_last_i      entry is the last pair of the kernel
//     pop_i            consume the head entry (ignored when empty)
//     valid_o          FIFO not empty
//     head_*_o         head entry fields (zero when empty)
//     count_o          number of stored entries (0..2)
// ---------------------------------------------------------------------------
module conv_pair_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_a_i,
  input  logic [DATA_W-1:0] push_data_b_i,
  input  logic              push_b_valid_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_data_a_o,
  output logic [DATA_W-1:0] head_data_b_o,
  output logic              head_b_valid_o,
  output logic              head_last_o,
  output logic [1:0]        count_o
);

  localparam int ENTRY_W = 2 * DATA_W + 2;

  logic [ENTRY_W-1:0] push_word;
  logic [ENTRY_W-1:0] head_word;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               pop_eff;
  logic               write_en;

  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic               head_bv;
  logic               head_last;

  assign push_word = {push_data_a_i, push_data_b_i, push_b_valid_i, push_last_i};
  assign pop_eff   = pop_i && (count_q != 2'd0);
  assign write_en  = push_i && !flush_i;

  // Storage: one register per slot, written when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [ENTRY_W-1:0] entry_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= '0;
      end else if (write_en && (wr_ptr_q == 1'(gi))) begin
        entry_q <= push_word;
      end
    end
  end

  assign head_word = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;

  // Pointer / occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_eff};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign {head_a, head_b, head_bv, head_last} = head_word;

  assign valid_o        = (count_q != 2'd0);
  assign head_data_a_o  = valid_o ? head_a : '0;
  assign head_data_b_o  = valid_o ? head_b : '0;
  assign head_b_valid_o = valid_o && head_bv;
  assign head_last_o    = valid_o && head_last;
  assign count_o        = count_q;

endmodule : conv_pair_fifo2

// File: rtl/conv2_kernel_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// conv2_kernel_fetch_ctrl
//   Reads one conv2 kernel out of a dual-port kernel ROM (1-cycle registered
//   read) and streams the weights as pairs to the MAC datapath. Port A reads
//   the even weight 2p, port B the odd weight 2p+1, so one pair per cycle is
//   delivered when the consumer never stalls.
//
//   Ports
//     clk_i          system clock
//     rst_ni         asynchronous active-low reset
//     start_i        1-cycle pulse, begins a fetch when idle
//     abort_i        synchronous flush back to IDLE, no done pulse
//     busy_o         high from FETCH entry until done/abort
//     done_o         1-cycle pulse after the last pair is accepted
//     rom_addr_a_o   ROM port A address (even weight)
//     rom_addr_b_o   ROM port B address (odd weight)
//     rom_q_a_i      ROM port A data, valid one cycle after the address
//     rom_q_b_i      ROM port B data
//     w_valid_o      output pair valid
//     w_ready_i      consumer accepts the pair
//     w_data_a_o     weight 2p
//     w_data_b_o     weight 2p+1, zero when lane B is masked
//     w_b_valid_o    lane B holds a real weight
//     w_last_o       marks the final pair of the kernel
// ---------------------------------------------------------------------------
module conv2_kernel_fetch_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int NUM_WEIGHTS = CONV2_NUM_WEIGHTS,
  parameter int BASE_ADDR   = CONV2_BASE_ADDR
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rom_addr_a_o,
  output logic [ADDR_W-1:0] rom_addr_b_o,
  input  logic [DATA_W-1:0] rom_q_a_i,
  input  logic [DATA_W-1:0] rom_q_b_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_a_o,
  output logic [DATA_W-1:0] w_data_b_o,
  output logic              w_b_valid_o,
  output logic              w_last_o
);

  localparam int                NPAIRS   = num_pairs(NUM_WEIGHTS);
  localparam logic [ADDR_W-1:0] LAST_P   = ADDR_W'(NPAIRS - 1);
  localparam logic              LAST_ODD = (NUM_WEIGHTS % 2) == 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  // Control state.
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;              // next pair to issue
  logic              inflight_q, inflight_d; // ROM read issued last cycle
  logic              infl_last_q, infl_last_d;
  logic              infl_bv_q, infl_bv_d;

  // Datapath / handshake helpers.
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic              pair_is_last;
  logic              pair_b_valid;
  logic [ADDR_W-1:0] addr_a;

  // -------------------------------------------------------------------------
  // Address generation, purely from the pair counter.
  // -------------------------------------------------------------------------
  assign pair_is_last = (p_q == LAST_P);
  // Lane B is empty only on the final pair of an odd-sized kernel.
  assign pair_b_valid = !(pair_is_last && LAST_ODD);

  assign addr_a       = BASE + (p_q << 1);
  assign rom_addr_a_o = addr_a;
  // Port B aliases port A when it has no weight to fetch (and while idle, so
  // both ports rest on weight 0).
  assign rom_addr_b_o = (pair_b_valid && (state_q != IDLE)) ? addr_a + ADDR_W'(1) : addr_a;

  // -------------------------------------------------------------------------
  // Issue decision. A read may only be issued if the FIFO will have a slot
  // for it when its data returns next cycle: entries held plus the read
  // already in flight, minus the beat leaving this cycle, must stay below 2.
  // -------------------------------------------------------------------------
  assign pop       = w_valid_o && w_ready_i;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue     = (state_q == FETCH) && !abort_i &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  // ROM data returned this cycle belongs to the read issued last cycle.
  assign push = inflight_q && !abort_i;

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    inflight_d  = 1'b0;
    infl_last_d = infl_last_q;
    infl_bv_d   = infl_bv_q;

    if (issue) begin
      p_d         = p_q + ADDR_W'(1);
      inflight_d  = 1'b1;
      infl_last_d = pair_is_last;
      infl_bv_d   = pair_b_valid;
    end

    unique case (state_q)
      IDLE: begin
        // abort in the same cycle as start keeps the block idle.
        if (start_i && !abort_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (issue && pair_is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (pop && w_last_o) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every return to IDLE rewinds the pair counter and drops any read
    // still in flight, so the next start always begins at pair 0.
    if (state_d == IDLE) begin
      p_d        = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      p_q         <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_bv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      infl_bv_q   <= infl_bv_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pair buffer between the ROM and the consumer.
  // -------------------------------------------------------------------------
  conv_pair_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (abort_i),
    .push_i         (push),
    .push_data_a_i  (rom_q_a_i),
    .push_data_b_i  (infl_bv_q ? rom_q_b_i : '0),
    .push_b_valid_i (infl_bv_q),
    .push_last_i    (infl_last_q),
    .pop_i          (pop),
    .valid_o        (w_valid_o),
    .head_data_a_o  (w_data_a_o),
    .head_data_b_o  (w_data_b_o),
    .head_b_valid_o (w_b_valid_o),
    .head_last_o    (w_last_o),
    .count_o        (fifo_count)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule : conv2_kernel_fetch_ctrl

// File: doc/conv2_kernel_fetch_ctrl.md
Name: conv2_kernel_fetch_ctrl

Overview:
Sequences reads of one conv2 kernel ROM (256 x 16-bit, dual-port, 1-cycle registered read) and streams the kernel weights as pairs to the conv2 MAC datapath over a valid/ready interface. Ports A and B fetch even and odd weights in parallel, so one pair is delivered per cycle when the consumer does not stall. The block sits between the layer sequencer (start/done/abort) and the conv2 MAC array. One instance is used per kernel-group ROM.

Parameters:
ADDR_W, 8, ROM address width
DATA_W, 16, weight width
NUM_WEIGHTS, 150, weights per kernel (5x5x6); range 1..2^ADDR_W
BASE_ADDR, 0, ROM address of weight 0; BASE_ADDR+NUM_WEIGHTS must be <= 2^ADDR_W

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a fetch when idle
abort  in  1  synchronous flush; returns to IDLE, no done
busy  out  1  high from FETCH entry until done/abort
done  out  1  1-cycle pulse after last pair accepted
rom_addr_a  out  ADDR_W  ROM port A address (even weight)
rom_addr_b  out  ADDR_W  ROM port B address (odd weight)
rom_q_a  in  DATA_W  ROM port A data, valid 1 cycle after address
rom_q_b  in  DATA_W  ROM port B data
w_valid  out  1  output pair valid
w_ready  in  1  consumer accepts pair
w_data_a  out  DATA_W  weight 2p
w_data_b  out  DATA_W  weight 2p+1; 0 when masked
w_b_valid  out  1  lane B holds a real weight (low only on last pair when NUM_WEIGHTS is odd)
w_last  out  1  marks pair NPAIRS-1

Behaviour:
- NPAIRS = ceil(NUM_WEIGHTS/2). Pair counter p (issued) and accepted-beat counter: ADDR_W bits each.
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, w_valid=0, w_last=0, w_b_valid=0, w_data_*=0, rom_addr_*=BASE_ADDR, FIFO empty, in-flight flag cleared.
- FSM: IDLE -> FETCH on start. FETCH -> DRAIN when pair NPAIRS-1 is issued. DRAIN -> DONE when the last beat is accepted (w_valid & w_ready & w_last). DONE -> IDLE after 1 cycle with done=1. abort in any non-IDLE state -> IDLE next cycle; FIFO and in-flight are discarded; done is not pulsed.
- start while not IDLE: ignored. start and abort in the same cycle in IDLE: abort wins, and the block stays IDLE.
- Addresses are combinational from p: rom_addr_a=BASE_ADDR+2p; rom_addr_b=BASE_ADDR+2p+1, except on an odd last pair, where rom_addr_b=rom_addr_a.
- Issue condition (FETCH only): fifo_count + inflight - pop < 2, where pop = w_valid & w_ready. On issue, p increments and inflight is set for the next cycle.
- Data capture: when inflight=1, {rom_q_a, rom_q_b or 0, b_valid, last} is written to a 2-entry FIFO. Writing and popping in the same cycle is legal.
- Output: w_* comes from the FIFO head, and w_valid = FIFO non-empty. Payload is held stable while w_valid & !w_ready.
- Latency: start sampled at edge 0 -> FETCH and addr p=0 in cycle 1 -> q in cycle 2 -> w_valid in cycle 3. With w_ready held high, throughput is 1 pair/cycle and the last beat is in cycle NPAIRS+2; done pulses in cycle NPAIRS+3.
- Backpressure: the FIFO never overflows, because the issue condition guarantees room for the in-flight read. No ROM read is dropped or duplicated.
- NUM_WEIGHTS=1 or 2: FETCH lasts 1 cycle, then DRAIN.
- Reset asserted mid-operation: immediate return to reset values. The next start restarts from p=0.

Decomposition:
- Shared package conv_pkg: ROM ADDR_W/DATA_W constants, the per-layer NUM_WEIGHTS/BASE_ADDR constants for conv2 groups, and the FSM state enum (IDLE, FETCH, DRAIN, DONE).
- One sub-module: conv_pair_fifo2, a 2-entry synchronous FIFO holding {data_a, data_b, b_valid, last} with count output. It is reused by the other conv weight fetchers.

Test Plan:
- ROM[i]=16'h1000+i, NUM_WEIGHTS=150, w_ready=1, start at cycle 0 -> 75 beats in cycles 3..77, with beat p = {1000+2p, 1001+2p}. w_last is set on beat 74 only; done pulses in cycle 78; busy is high in cycles 1..78.
- Same setup with w_ready toggling 1,0,0,1 -> payload is stable during stalls, all 75 pairs arrive in order with none duplicated, and FIFO count never exceeds 2.
- NUM_WEIGHTS=5, BASE_ADDR=8'h40 -> 3 beats; beat 2 has w_data_a=ROM[0x44], w_data_b=0, w_b_valid=0, w_last=1.
- abort in cycle 20 of a fetch -> w_valid=0 and busy=0 from cycle 21, with no done. A new start then yields the first beat = ROM[BASE], {1000,1001}.
- start pulsed at cycle 10 during a fetch -> ignored, and the beat count stays 75. reset_n pulled low at cycle 30 -> all outputs return to 0 immediately.
- NUM_WEIGHTS=1, w_ready=0 for 5 cycles then 1 -> a single beat is held stable, w_last=1 and w_b_valid=0, and done pulses the cycle after acceptance.
